elevator_scan_ctrl: RTL and testbench
=====================================

Name: elevator_scan_ctrl

Overview:
- Parametrised next-generation single-car controller for N_FLOORS floors.
- Latches floor-call requests in a pending bitmask and serves them in SCAN order: keeps going in one direction while calls remain ahead, then reverses.
- Models per-floor travel time, a timed door-open dwell, and a saturating idle detector.
- Instantiated once per car under the multi-car top level; each car has its own reset.

Parameters:
- N_FLOORS, 8, number of floors (2..16).
- FLOOR_W, $clog2(N_FLOORS), floor index width.
- MOVE_CYCLES, 2, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, 3, cycles door_open stays high per stop (>=1).
- IDLE_LIMIT, 10, IDLE cycles before idle_flag asserts (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req  input  N_FLOORS  call pulses; bit i = call to floor i; any number of bits per cycle
- cur_floor  output  FLOOR_W  last floor reached
- dir_up  output  1  1 = up, 0 = down
- moving  output  1  high while in MOVE
- door_open  output  1  high while in DOOR
- arrive  output  1  one-cycle pulse on each cur_floor update
- pending  output  N_FLOORS  latched, unserved calls
- idle_flag  output  1  high once IDLE has lasted IDLE_LIMIT cycles

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cur_floor=0, dir_up=1, pending=0.
  - moving=0, door_open=0, arrive=0, idle_flag=0.
  - All timers = 0.
- All outputs are registered.
- pending update each edge: pending <= (pending | req) & ~clr_mask.
  - clr_mask = the current-floor bit on the edge that enters DOOR.
  - A req for cur_floor while in DOOR is not latched; it reloads the door timer instead.
  - On all other edges, set and clear of the same bit cannot coincide.
- Decision logic uses registered pending only: a req at edge t is visible at t+1 and acted on at t+2.
- Definitions: ahead = pending bits strictly beyond cur_floor in dir_up; behind = bits strictly on the other side.
- IDLE:
  - pending[cur_floor] -> DOOR.
  - Else if ahead != 0 -> MOVE, keep dir.
  - Else if behind != 0 -> MOVE, flip dir_up.
  - Else stay in IDLE.
- MOVE:
  - Timer counts MOVE_CYCLES cycles.
  - On expiry, cur_floor steps ±1 and arrive pulses on that same edge.
  - Evaluate the new floor with IDLE rules: DOOR / continue / reverse / IDLE.
  - Never steps below 0 or above N_FLOORS-1; direction is re-evaluated first at the end floors.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, counted from the entry edge.
  - A req for cur_floor during DOOR reloads the timer to a full DOOR_CYCLES.
  - On expiry, evaluate with IDLE rules on the same edge; door_open falls and moving can rise on that edge.
- Idle counter:
  - Increments each cycle in IDLE, saturating at IDLE_LIMIT.
  - idle_flag=1 when count==IDLE_LIMIT.
  - Counter and flag both clear on the edge that leaves IDLE.
- Reset mid-MOVE or mid-DOOR: immediate return to reset values; pending calls are discarded.
- moving and door_open are never high together.

Test Plan:
1. Rst release, req=0x08 pulse at c0 (floor 0):
   - pending=0x08 at c1; moving=1 at c2.
   - cur_floor=1 at c4, =2 at c6, =3 at c8, arrive pulse each time.
   - At c8: door_open=1, pending=0.
   - door_open low and IDLE at c11.
2. Car at floor 3 moving up, pending={1,5,6}:
   - Stops in order 5, 6, then reverses (dir_up=0) to 1.
   - No stop at 4, 3 or 2.
3. No requests after reset:
   - idle_flag=0 through c9, 1 at c10, stays high.
   - req=0x02 at c15 -> idle_flag=0 at c17 when MOVE is entered.
4. In DOOR at floor 2 with 1 cycle left, req=0x04:
   - Timer reloads; door_open stays high 3 more cycles.
   - pending[2] remains 0.
5. Async rst low mid-MOVE between floors 4 and 5:
   - Immediately: cur_floor=0, moving=0, pending=0, dir_up=1.
6. N_FLOORS=4, at floor 0 IDLE, req=0x09:
   - Door opens at floor 0 first (clears bit 0), then moves up to 3.
   - Stops at floor 3, cur_floor never exceeds 3; dir_up remains 1 until a lower call arrives.

Source files
------------

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches floor calls and serves them in sweep order,
// with per-floor travel time, a reloadable door dwell and a saturating idle detector.
module elevator_scan_ctrl #(
   parameter int N_FLOORS    = 8,
   parameter int FLOOR_W     = $clog2(N_FLOORS),
   parameter int MOVE_CYCLES = 2,
   parameter int DOOR_CYCLES = 3,
   parameter int IDLE_LIMIT  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] req,
   output logic [FLOOR_W-1:0]  cur_floor,
   output logic                dir_up,
   output logic                moving,
   output logic                door_open,
   output logic                arrive,
   output logic [N_FLOORS-1:0] pending,
   output logic                idle_flag
);
   localparam int TMR_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int IDL_W   = $clog2(IDLE_LIMIT + 1);
   localparam logic [N_FLOORS-1:0] FLOOR_ONE = {{(N_FLOORS-1){1'b0}}, 1'b1};
   localparam logic [TMR_W-1:0]    MOVE_LAST = TMR_W'(MOVE_CYCLES - 1);
   localparam logic [TMR_W-1:0]    DOOR_LAST = TMR_W'(DOOR_CYCLES - 1);
   localparam logic [IDL_W-1:0]    IDLE_MAX  = IDL_W'(IDLE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

   state_t              state;
   logic [TMR_W-1:0]    timer;
   logic [IDL_W-1:0]    idle_cnt;

   logic [FLOOR_W-1:0]  step_floor;
   logic [FLOOR_W-1:0]  eval_floor;
   logic [N_FLOORS-1:0] eval_bit;
   logic [N_FLOORS-1:0] cur_bit;
   logic [N_FLOORS-1:0] above;
   logic [N_FLOORS-1:0] below;
   logic                ahead_any;
   logic                behind_any;
   logic                here;
   logic                move_done;
   logic                door_reload;
   logic                door_done;
   logic                evaluate;
   logic                go_door;
   logic                go_move;
   logic                go_flip;
   logic                stay_idle;
   logic [N_FLOORS-1:0] pending_nxt;
   logic [IDL_W-1:0]    idle_cnt_nxt;

   // The scan decision is taken for the floor the car will occupy after this edge:
   // the next floor when a move step completes, otherwise the current one.
   always_comb begin
      step_floor = dir_up ? cur_floor + 1'b1 : cur_floor - 1'b1;
      move_done  = (state == S_MOVE) && (timer == MOVE_LAST);
      eval_floor = move_done ? step_floor : cur_floor;
      eval_bit   = FLOOR_ONE << eval_floor;
      cur_bit    = FLOOR_ONE << cur_floor;
      above      = '0;
      below      = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         above[i] = FLOOR_W'(i) > eval_floor;
         below[i] = FLOOR_W'(i) < eval_floor;
      end
      ahead_any  = |(pending & (dir_up ? above : below));
      behind_any = |(pending & (dir_up ? below : above));
      here       = |(pending & eval_bit);

      // A call for the open floor keeps the door open instead of being latched.
      door_reload = (state == S_DOOR) && (|(req & cur_bit));
      door_done   = (state == S_DOOR) && !door_reload && (timer == DOOR_LAST);
      evaluate    = (state == S_IDLE) || move_done || door_done;
      go_door     = evaluate && here;
      go_move     = evaluate && !here && (ahead_any || behind_any);
      go_flip     = go_move && !ahead_any;

      pending_nxt = (pending | (req & ~((state == S_DOOR) ? cur_bit : '0)))
                    & ~(go_door ? eval_bit : '0);

      stay_idle    = (state == S_IDLE) && !go_door && !go_move;
      idle_cnt_nxt = !stay_idle ? '0 :
                     (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cur_floor <= '0;
         dir_up    <= 1'b1;
         moving    <= 1'b0;
         door_open <= 1'b0;
         arrive    <= 1'b0;
         pending   <= '0;
         idle_flag <= 1'b0;
         timer     <= '0;
         idle_cnt  <= '0;
      end else begin
         pending   <= pending_nxt;
         idle_cnt  <= idle_cnt_nxt;
         idle_flag <= (idle_cnt_nxt == IDLE_MAX);
         arrive    <= move_done;
         if (move_done) cur_floor <= step_floor;

         if (evaluate) begin
            timer <= '0;
            if (go_door) begin
               state     <= S_DOOR;
               moving    <= 1'b0;
               door_open <= 1'b1;
            end else if (go_move) begin
               state     <= S_MOVE;
               moving    <= 1'b1;
               door_open <= 1'b0;
               if (go_flip) dir_up <= ~dir_up;
            end else begin
               state     <= S_IDLE;
               moving    <= 1'b0;
               door_open <= 1'b0;
            end
         end else if (door_reload) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: vector table, directed corner sequences on an 8-floor and a
// 4-floor car, then random calls checked against an event-level SCAN model.
module tb_elevator_scan_ctrl;
   localparam int MOVE_C = 2;
   localparam int DOOR_C = 3;
   localparam int IDLE_L = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] req = '0;
   logic [2:0] cur_floor;
   logic       dir_up, moving, door_open, arrive, idle_flag;
   logic [7:0] pending;

   logic       rst4 = 1'b0;
   logic [3:0] req4 = '0;
   logic [1:0] cur4;
   logic       dir4, moving4, door4, arrive4, idle4;
   logic [3:0] pend4;

   int errors = 0;
   int checks = 0;

   elevator_scan_ctrl dut (
      .clk(clk), .rst(rst), .req(req), .cur_floor(cur_floor), .dir_up(dir_up),
      .moving(moving), .door_open(door_open), .arrive(arrive), .pending(pending),
      .idle_flag(idle_flag)
   );

   elevator_scan_ctrl #(.N_FLOORS(4)) dut4 (
      .clk(clk), .rst(rst4), .req(req4), .cur_floor(cur4), .dir_up(dir4),
      .moving(moving4), .door_open(door4), .arrive(arrive4), .pending(pend4),
      .idle_flag(idle4)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      req  = '0;
      req4 = '0;
      rst  = 1'b0;
      rst4 = 1'b0;
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      rst4 = 1'b1;
   endtask

   // driver tasks: drive at negedge, DUT samples at posedge, outputs read at next negedge
   task automatic tick(input logic [7:0] r);
      req = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick4(input logic [3:0] r);
      req4 = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   // reference model: calls as a bitmask, countdown of remaining cycles per activity
   bit [7:0] m_calls;
   int       m_floor, m_left, m_idle_cycles;
   bit       m_up, m_moving, m_door, m_arrive, m_flag;

   // 0 = rest, 1 = open door here, 2 = travel on, 3 = turn around
   function automatic int scan_choice(int f, bit up, bit [7:0] calls);
      bit above_any = 1'b0;
      bit below_any = 1'b0;
      if (calls[f]) return 1;
      for (int i = 0; i < 8; i++) begin
         if (calls[i] && i > f) above_any = 1'b1;
         if (calls[i] && i < f) below_any = 1'b1;
      end
      if (up ? above_any : below_any) return 2;
      if (up ? below_any : above_any) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      m_calls = '0; m_floor = 0; m_up = 1'b1; m_moving = 1'b0; m_door = 1'b0;
      m_arrive = 1'b0; m_flag = 1'b0; m_left = 0; m_idle_cycles = 0;
   endtask

   task automatic model_step(input bit [7:0] r);
      bit [7:0] seen;
      bit       decide, was_idle;
      int       choice;
      seen     = m_calls;
      was_idle = !m_moving && !m_door;
      m_arrive = 1'b0;
      decide   = 1'b0;
      if (m_door) begin
         if (r[m_floor]) begin
            m_left = DOOR_C;
            r[m_floor] = 1'b0;
         end else begin
            m_left--;
            decide = (m_left == 0);
         end
      end else if (m_moving) begin
         m_left--;
         if (m_left == 0) begin
            m_floor  = m_up ? m_floor + 1 : m_floor - 1;
            m_arrive = 1'b1;
            decide   = 1'b1;
         end
      end else begin
         decide = 1'b1;
      end
      m_calls = m_calls | r;
      if (decide) begin
         choice = scan_choice(m_floor, m_up, seen);
         m_door   = (choice == 1);
         m_moving = (choice >= 2);
         if (choice == 1) begin
            m_left = DOOR_C;
            m_calls[m_floor] = 1'b0;
         end
         if (choice >= 2) m_left = MOVE_C;
         if (choice == 3) m_up = !m_up;
      end
      if (was_idle && !m_moving && !m_door)
         m_idle_cycles = (m_idle_cycles < IDLE_L) ? m_idle_cycles + 1 : IDLE_L;
      else
         m_idle_cycles = 0;
      m_flag = (m_idle_cycles == IDLE_L);
   endtask

   task automatic model_compare(input string tag);
      chk({tag, "_cur_floor"}, 32'(cur_floor), 32'(m_floor));
      chk({tag, "_dir_up"}, 32'(dir_up), 32'(m_up));
      chk({tag, "_moving"}, 32'(moving), 32'(m_moving));
      chk({tag, "_door_open"}, 32'(door_open), 32'(m_door));
      chk({tag, "_arrive"}, 32'(arrive), 32'(m_arrive));
      chk({tag, "_pending"}, 32'(pending), 32'(m_calls));
      chk({tag, "_idle_flag"}, 32'(idle_flag), 32'(m_flag));
      chk({tag, "_exclusive"}, 32'(moving & door_open), 32'd0);
   endtask

   // table: req driven before edge k, expected outputs after edge k
   typedef struct packed {
      logic [7:0] req;
      logic [2:0] floor;
      logic       up, mv, door, arr;
      logic [7:0] pend;
      logic       idle;
   } vec_t;

   vec_t vecs[12];

   task automatic test_single_call();
      vec_t act;
      vecs[0]  = '{8'h08, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0};
      vecs[1]  = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0};
      vecs[2]  = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0};
      vecs[3]  = '{8'h00, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b0};
      vecs[4]  = '{8'h00, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0};
      vecs[5]  = '{8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b0};
      vecs[6]  = '{8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0};
      vecs[7]  = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[8]  = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[9]  = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[10] = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[11] = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      do_reset();
      act = '{8'h00, cur_floor, dir_up, moving, door_open, arrive, pending, idle_flag};
      chk("reset_outputs", 32'(act), 32'({8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
      chk("reset_outputs_n4", 32'({cur4, dir4, moving4, door4, arrive4, pend4, idle4}),
          32'({2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0}));
      for (int k = 0; k < 12; k++) begin
         tick(vecs[k].req);
         act = '{vecs[k].req, cur_floor, dir_up, moving, door_open, arrive, pending, idle_flag};
         chk($sformatf("t1_cycle%0d", k + 1), 32'(act), 32'(vecs[k]));
      end
   endtask

   task automatic test_scan_order();
      logic [2:0] exp_q[$];
      logic [2:0] got;
      logic       found, prev_door;
      int         n;
      do_reset();
      tick(8'h20);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick(8'h00);
         if (arrive && cur_floor == 3'd3) found = 1'b1;
      end
      chk("t2_reach_floor3", 32'(found), 32'd1);
      chk("t2_moving_up_at3", 32'({moving, dir_up}), 32'b11);
      tick(8'h42);
      exp_q = {3'd5, 3'd6, 3'd1};
      prev_door = door_open;
      n = 0;
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
         tick(8'h00);
         if (door_open && !prev_door) begin
            got = exp_q.pop_front();
            chk($sformatf("t2_stop%0d_floor", n), 32'(cur_floor), 32'(got));
            if (got == 3'd1) chk("t2_dir_down_at1", 32'(dir_up), 32'd0);
            n++;
         end
         prev_door = door_open;
      end
      chk("t2_all_stops_served", 32'(exp_q.size()), 32'd0);
      chk("t2_pending_empty", 32'(pending), 32'd0);
   endtask

   task automatic test_idle_flag();
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         tick(8'h00);
         chk($sformatf("t3_idle_c%0d", k), 32'(idle_flag), 32'd0);
      end
      for (int k = 10; k <= 15; k++) begin
         tick(8'h00);
         chk($sformatf("t3_idle_c%0d", k), 32'(idle_flag), 32'd1);
      end
      tick(8'h02);
      chk("t3_idle_c16", 32'({idle_flag, moving}), 32'b10);
      tick(8'h00);
      chk("t3_idle_c17", 32'({idle_flag, moving}), 32'b01);
   endtask

   task automatic test_door_reload();
      logic found;
      do_reset();
      tick(8'h04);
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         tick(8'h00);
         if (door_open) found = 1'b1;
      end
      chk("t4_door_reached", 32'(found), 32'd1);
      chk("t4_door_floor", 32'(cur_floor), 32'd2);
      tick(8'h00);
      tick(8'h00);
      chk("t4_door_last_cycle", 32'(door_open), 32'd1);
      tick(8'h04);
      chk("t4_door_reloaded", 32'(door_open), 32'd1);
      chk("t4_pending2_clear", 32'(pending), 32'd0);
      tick(8'h00);
      chk("t4_door_plus2", 32'(door_open), 32'd1);
      tick(8'h00);
      chk("t4_door_plus3", 32'(door_open), 32'd1);
      tick(8'h00);
      chk("t4_door_closed", 32'({door_open, moving}), 32'd0);
   endtask

   task automatic test_async_reset();
      logic found;
      do_reset();
      tick(8'h80);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick(8'h00);
         if (arrive && cur_floor == 3'd4) found = 1'b1;
      end
      chk("t5_reach_floor4", 32'(found), 32'd1);
      tick(8'h00);
      chk("t5_mid_move", 32'({moving, pending}), 32'({1'b1, 8'h80}));
      #2 rst = 1'b0;
      #1;
      chk("t5_async_outputs",
          32'({cur_floor, dir_up, moving, door_open, arrive, pending, idle_flag}),
          32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_four_floors();
      logic found, dir_ok;
      do_reset();
      tick4(4'h9);
      chk("t6_pending_latched", 32'(pend4), 32'h9);
      tick4(4'h0);
      chk("t6_door_at0", 32'({door4, moving4, cur4, pend4}), 32'({1'b1, 1'b0, 2'd0, 4'h8}));
      found  = 1'b0;
      dir_ok = 1'b1;
      for (int c = 0; c < 40 && !found; c++) begin
         tick4(4'h0);
         if (!dir4) dir_ok = 1'b0;
         if (door4 && cur4 == 2'd3) found = 1'b1;
      end
      chk("t6_stop_at3", 32'(found), 32'd1);
      chk("t6_dir_held_up", 32'(dir_ok), 32'd1);
      repeat (5) tick4(4'h0);
      chk("t6_rest_at_top", 32'({cur4, dir4, moving4, door4, pend4}),
          32'({2'd3, 1'b1, 1'b0, 1'b0, 4'h0}));
      tick4(4'h1);
      tick4(4'h0);
      chk("t6_reverse_down", 32'({moving4, dir4}), 32'b10);
   endtask

   task automatic test_random();
      logic [7:0] one8;
      logic [7:0] r;
      int         density;
      one8 = 8'h01;
      do_reset();
      model_reset();
      model_compare("rand_reset");
      for (int seg = 0; seg < 8; seg++) begin
         density = (seg % 2 == 0) ? 3 : 40;
         for (int c = 0; c < 100; c++) begin
            r = 8'h00;
            if ($urandom_range(0, density - 1) == 0) r = one8 << $urandom_range(0, 7);
            if ($urandom_range(0, 29) == 0) r = 8'($urandom_range(0, 255));
            if (m_door && $urandom_range(0, 3) == 0) r[m_floor] = 1'b1;
            req = r;
            @(posedge clk);
            model_step(r);
            @(negedge clk);
            model_compare("rand");
         end
         if (seg == 2 || seg == 5) begin
            req = 8'h00;
            #2 rst = 1'b0;
            model_reset();
            #1;
            model_compare("rand_async");
            @(negedge clk);
            rst = 1'b1;
         end
      end
   endtask

   initial begin
      test_single_call();
      test_scan_order();
      test_idle_flag();
      test_door_reload();
      test_async_reset();
      test_four_floors();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
